// File: rtl/action_modifier_pipe_if.sv
// Request/result handshake bundle for action_modifier_pipe.
// The slave side is the modifier; the master side issues requests and consumes results.
interface action_modifier_pipe_if #(
    parameter int ACTION_WIDTH = 32,
    parameter int NUM_FIELDS   = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [ACTION_WIDTH-1:0]   action_in;
    logic [ACTION_WIDTH-1:0]   param;
    logic [2*NUM_FIELDS-1:0]   mode;
    logic                      out_valid;
    logic                      out_ready;
    logic [ACTION_WIDTH-1:0]   action_out;
    logic                      changed;

    modport slave (
        input  in_valid, action_in, param, mode, out_ready,
        output in_ready, out_valid, action_out, changed
    );

    modport master (
        output in_valid, action_in, param, mode, out_ready,
        input  in_ready, out_valid, action_out, changed
    );
endinterface

// File: rtl/action_modifier_pipe.sv
// Two-stage action-word modifier: per-field keep/replace/OR/clear merge, change
// detection, and a saturating count of delivered changed results.
`ifndef OPENFLOW_ACTION_WIDTH
`define OPENFLOW_ACTION_WIDTH   256
`define OPENFLOW_IN_PORT_POS    0
`define OPENFLOW_IN_PORT_WIDTH  16
`define OPENFLOW_DL_SRC_POS     16
`define OPENFLOW_DL_SRC_WIDTH   48
`define OPENFLOW_DL_DST_POS     64
`define OPENFLOW_DL_DST_WIDTH   48
`define OPENFLOW_VLAN_ID_POS    112
`define OPENFLOW_VLAN_ID_WIDTH  12
`define OPENFLOW_VLAN_PCP_POS   124
`define OPENFLOW_VLAN_PCP_WIDTH 3
`define OPENFLOW_DL_TYPE_POS    128
`define OPENFLOW_DL_TYPE_WIDTH  16
`define OPENFLOW_NW_SRC_POS     144
`define OPENFLOW_NW_SRC_WIDTH   32
`define OPENFLOW_NW_DST_POS     176
`define OPENFLOW_NW_DST_WIDTH   32
`define OPENFLOW_NW_PROTO_POS   208
`define OPENFLOW_NW_PROTO_WIDTH 8
`define OPENFLOW_TP_SRC_POS     216
`define OPENFLOW_TP_SRC_WIDTH   16
`define OPENFLOW_TP_DST_POS     232
`define OPENFLOW_TP_DST_WIDTH   16
`endif

module action_modifier_pipe #(
    parameter int ACTION_WIDTH = `OPENFLOW_ACTION_WIDTH,
    parameter int NUM_FIELDS   = 11,
    parameter logic [NUM_FIELDS*16-1:0] FIELD_POS = {
        16'(`OPENFLOW_TP_DST_POS),   16'(`OPENFLOW_TP_SRC_POS),
        16'(`OPENFLOW_NW_PROTO_POS), 16'(`OPENFLOW_NW_DST_POS),
        16'(`OPENFLOW_NW_SRC_POS),   16'(`OPENFLOW_DL_TYPE_POS),
        16'(`OPENFLOW_VLAN_PCP_POS), 16'(`OPENFLOW_VLAN_ID_POS),
        16'(`OPENFLOW_DL_DST_POS),   16'(`OPENFLOW_DL_SRC_POS),
        16'(`OPENFLOW_IN_PORT_POS)},
    parameter logic [NUM_FIELDS*16-1:0] FIELD_WIDTH = {
        16'(`OPENFLOW_TP_DST_WIDTH),   16'(`OPENFLOW_TP_SRC_WIDTH),
        16'(`OPENFLOW_NW_PROTO_WIDTH), 16'(`OPENFLOW_NW_DST_WIDTH),
        16'(`OPENFLOW_NW_SRC_WIDTH),   16'(`OPENFLOW_DL_TYPE_WIDTH),
        16'(`OPENFLOW_VLAN_PCP_WIDTH), 16'(`OPENFLOW_VLAN_ID_WIDTH),
        16'(`OPENFLOW_DL_DST_WIDTH),   16'(`OPENFLOW_DL_SRC_WIDTH),
        16'(`OPENFLOW_IN_PORT_WIDTH)},
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    action_modifier_pipe_if.slave  bus,
    input  logic                   clear_count,
    output logic [COUNT_WIDTH-1:0] mod_count
);

    logic [ACTION_WIDTH-1:0] merged_s;
    logic                    s1_adv_s;
    logic                    s2_adv_s;
    logic                    s1_valid_r;
    logic [ACTION_WIDTH-1:0] s1_merged_r;
    logic [ACTION_WIDTH-1:0] s1_orig_r;
    logic                    out_valid_r;
    logic [ACTION_WIDTH-1:0] action_out_r;
    logic                    changed_r;
    logic [COUNT_WIDTH-1:0]  mod_count_r;

    // Per-bit op select: scanning fields upward lets the highest non-keep field win overlaps.
    always_comb begin : merge_comb
        logic [1:0] op_v;
        int         pos_v;
        int         wid_v;
        merged_s = bus.action_in;
        op_v     = 2'b00;
        pos_v    = 32'sd0;
        wid_v    = 32'sd0;
        for (int b = 0; b < ACTION_WIDTH; b++) begin
            op_v = 2'b00;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                pos_v = int'(FIELD_POS[16*i +: 16]);
                wid_v = int'(FIELD_WIDTH[16*i +: 16]);
                op_v  = ((wid_v != 32'sd0) && (b >= pos_v) && (b < pos_v + wid_v) &&
                         (bus.mode[2*i +: 2] != 2'b00)) ? bus.mode[2*i +: 2] : op_v;
            end
            case (op_v)
                2'b01:   merged_s[b] = bus.param[b];
                2'b10:   merged_s[b] = bus.action_in[b] | bus.param[b];
                2'b11:   merged_s[b] = bus.action_in[b] & ~bus.param[b];
                default: merged_s[b] = bus.action_in[b];
            endcase
        end
    end

    assign s2_adv_s     = !out_valid_r || bus.out_ready;
    assign s1_adv_s     = !s1_valid_r || s2_adv_s;
    assign bus.in_ready = s1_adv_s && !reset;

    // Pipeline stages: S1 holds merged + original word, S2 holds the result and change flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r   <= 1'b0;
            s1_merged_r  <= '0;
            s1_orig_r    <= '0;
            out_valid_r  <= 1'b0;
            action_out_r <= '0;
            changed_r    <= 1'b0;
        end else begin
            if (s1_adv_s) begin
                s1_valid_r <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_merged_r <= merged_s;
                    s1_orig_r   <= bus.action_in;
                end
            end
            if (s2_adv_s) begin
                out_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    action_out_r <= s1_merged_r;
                    changed_r    <= (s1_merged_r != s1_orig_r);
                end
            end
        end
    end

    // Saturating count of delivered changed results; clear wins over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            mod_count_r <= '0;
        end else if (clear_count) begin
            mod_count_r <= '0;
        end else if (out_valid_r && bus.out_ready && changed_r &&
                     (mod_count_r != {COUNT_WIDTH{1'b1}})) begin
            mod_count_r <= mod_count_r + COUNT_WIDTH'(1);
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.action_out = action_out_r;
    assign bus.changed    = changed_r;
    assign mod_count      = mod_count_r;

endmodule

// File: tb/tb_action_modifier_pipe.sv
// Randomised and directed bench for action_modifier_pipe against a mask-based reference model.
module tb_action_modifier_pipe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear_count = 1'b0;
    logic [3:0] mod_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] exp_q[$];
    int          exp_cnt = 0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_a = 32'h0;
    logic        hold_c = 1'b0;

    int fpos[4] = '{0, 8, 4, 16};
    int fwid[4] = '{8, 8, 8, 0};

    always #5 clk = ~clk;

    action_modifier_pipe_if #(.ACTION_WIDTH(32), .NUM_FIELDS(4)) bus ();

    action_modifier_pipe #(
        .ACTION_WIDTH (32),
        .NUM_FIELDS   (4),
        .FIELD_POS    ({16'd16, 16'd4, 16'd8, 16'd0}),
        .FIELD_WIDTH  ({16'd0,  16'd8, 16'd8, 16'd8}),
        .COUNT_WIDTH  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .clear_count (clear_count),
        .mod_count   (mod_count)
    );

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-word masks per field; later fields overwrite earlier ones, zero-width masks are empty.
    function automatic logic [32:0] ref_model(input logic [31:0] a, input logic [31:0] p,
                                              input logic [7:0] m);
        logic [31:0] r, mask, nv;
        r = a;
        for (int i = 0; i < 4; i++) begin
            mask = ((32'h1 << fwid[i]) - 32'h1) << fpos[i];
            case (m[2*i +: 2])
                2'b01:   nv = p;
                2'b10:   nv = a | p;
                2'b11:   nv = a & ~p;
                default: nv = r;
            endcase
            r = (r & ~mask) | (nv & mask);
        end
        return {(r != a), r};
    endfunction

    task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] p,
                        input logic [7:0] m, input logic ordy, input logic clr,
                        output logic acc);
        logic [32:0] e;
        logic        ohs;
        e = 33'h0;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.action_in = a;
        bus.param     = p;
        bus.mode      = m;
        bus.out_ready = ordy;
        clear_count   = clr;
        #1;
        chk_eq("in_ready", bus.in_ready, !(exp_q.size() == 2 && !ordy));
        if (hold_v) begin
            chk_eq("hold_valid", bus.out_valid, 1'b1);
            chk_eq("hold_action", bus.action_out, hold_a);
            chk_eq("hold_changed", bus.changed, hold_c);
        end
        acc = iv && bus.in_ready;
        ohs = bus.out_valid && ordy;
        if (ohs) begin
            if (exp_q.size() == 0) begin
                chk_eq("spurious_out", bus.out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk_eq("action_out", bus.action_out, e[31:0]);
                chk_eq("changed", bus.changed, e[32]);
            end
        end
        hold_v = bus.out_valid && !ordy;
        hold_a = bus.action_out;
        hold_c = bus.changed;
        if (acc) exp_q.push_back(ref_model(a, p, m));
        if (clr) exp_cnt = 0;
        else if (ohs && e[32] && exp_cnt != 15) exp_cnt++;
        @(posedge clk);
        #1;
        chk_eq("mod_count", mod_count, exp_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clear_count   = 1'b0;
        @(posedge clk);
        #1;
        chk_eq("rst_out_valid", bus.out_valid, 1'b0);
        chk_eq("rst_action_out", bus.action_out, 32'h0);
        chk_eq("rst_changed", bus.changed, 1'b0);
        chk_eq("rst_mod_count", mod_count, 4'h0);
        chk_eq("rst_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        hold_v  = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic send_one(input logic [31:0] a, input logic [31:0] p, input logic [7:0] m,
                            input logic [31:0] exp_a, input logic exp_c);
        logic acc;
        step(1'b1, a, p, m, 1'b1, 1'b0, acc);
        chk_eq("one_accept", acc, 1'b1);
        chk_eq("lat_early", bus.out_valid, 1'b0);
        step(1'b0, 32'h0, 32'h0, 8'h0, 1'b1, 1'b0, acc);
        chk_eq("lat_valid", bus.out_valid, 1'b1);
        chk_eq("exp_action", bus.action_out, exp_a);
        chk_eq("exp_changed", bus.changed, exp_c);
        step(1'b0, 32'h0, 32'h0, 8'h0, 1'b1, 1'b0, acc);
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++)
            step(1'b0, 32'h0, 32'h0, 8'h0, 1'b1, 1'b0, acc);
        chk_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc;
        logic [31:0] a;
        int          sent;
        int          ordy_pat[4] = '{1, 0, 0, 1};
        bus.in_valid  = 1'b0;
        bus.action_in = 32'h0;
        bus.param     = 32'h0;
        bus.mode      = 8'h0;
        bus.out_ready = 1'b0;
        do_reset();

        // Directed merge cases: OR + replace, keep-all, clear, overlap with a zero-width field.
        send_one(32'h1234_56F0, 32'h0000_AB0F, 8'b00_00_01_10, 32'h1234_ABFF, 1'b1);
        chk_eq("count_after_first", mod_count, 4'h1);
        send_one(32'h1234_56F0, 32'h0000_AB0F, 8'b00_00_00_00, 32'h1234_56F0, 1'b0);
        chk_eq("count_keep", mod_count, 4'h1);
        send_one(32'h1234_56F0, 32'h0000_0600, 8'b00_00_11_00, 32'h1234_50F0, 1'b1);
        send_one(32'h1234_5678, 32'hFFFF_ABCD, 8'b01_01_00_01, 32'h1234_5BCD, 1'b1);

        // Eight back-to-back requests under a 1,0,0,1 out_ready pattern.
        sent = 0;
        for (int k = 0; k < 100 && (sent < 8 || exp_q.size() != 0); k++) begin
            step(sent < 8, $urandom, $urandom, 8'($urandom), ordy_pat[k % 4] != 0, 1'b0, acc);
            if (acc) sent++;
        end
        chk_eq("b2b_sent", sent, 8);
        chk_eq("b2b_drained", exp_q.size(), 0);

        // Saturation at 0xF, then clear colliding with a changed handshake.
        step(1'b0, 32'h0, 32'h0, 8'h0, 1'b1, 1'b1, acc);
        sent = 0;
        for (int k = 0; k < 100 && sent < 17; k++) begin
            a = $urandom;
            step(1'b1, a, ~a, 8'b00_00_00_01, 1'b1, 1'b0, acc);
            if (acc) sent++;
        end
        drain();
        chk_eq("count_saturated", mod_count, 4'hF);
        a = $urandom;
        step(1'b1, a, ~a, 8'b00_00_00_01, 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0, acc);
        chk_eq("clr_setup_valid", bus.out_valid, 1'b1);
        step(1'b0, 32'h0, 32'h0, 8'h0, 1'b1, 1'b1, acc);
        chk_eq("clear_priority", mod_count, 4'h0);

        // Random traffic, backpressure and occasional clears.
        for (int k = 0; k < 400; k++)
            step(($urandom & 3) != 0, $urandom, $urandom, 8'($urandom),
                 ($urandom & 1) != 0, ($urandom_range(0, 15) == 0), acc);
        drain();

        // Reset with both stages full.
        send_one(32'h0000_0000, 32'h0000_00FF, 8'b00_00_00_01, 32'h0000_00FF, 1'b1);
        step(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 8'hFF, 1'b0, 1'b0, acc);
        step(1'b1, 32'h1111_1111, 32'h2222_2222, 8'h55, 1'b0, 1'b0, acc);
        chk_eq("both_full", exp_q.size(), 2);
        chk_eq("pre_rst_count_nz", mod_count != 4'h0, 1'b1);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 32'h0, 32'h0, 8'h0, 1'b1, 1'b0, acc);
            chk_eq("post_rst_quiet", bus.out_valid, 1'b0);
        end
        send_one(32'h1234_56F0, 32'h0000_AB0F, 8'b00_00_01_10, 32'h1234_ABFF, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/action_modifier_pipe.md
ACTION_MODIFIER_PIPE -- requirements
Module: action_modifier_pipe

Interface
REQ-001 SHALL have parameter ACTION_WIDTH, default `OPENFLOW_ACTION_WIDTH, width of the action word.
REQ-002 SHALL have parameter NUM_FIELDS, default 11, number of modifiable fields.
REQ-003 SHALL have parameter FIELD_POS, default packed per-field LSB positions from the `OPENFLOW_*_POS macros, NUM_FIELDS x 16 bits, field i at [16i +: 16].
REQ-004 SHALL have parameter FIELD_WIDTH, default packed per-field widths from the `OPENFLOW_*_WIDTH macros, NUM_FIELDS x 16 bits, same packing.
REQ-005 SHALL have parameter COUNT_WIDTH, default 32, width of the modification counter.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  request present on action_in/param/mode.
REQ-009 in_ready  output  1  request accepted this cycle when in_valid & in_ready.
REQ-010 action_in  input  ACTION_WIDTH  original action word.
REQ-011 param  input  ACTION_WIDTH  modification operand, field-aligned like action_in.
REQ-012 mode  input  2*NUM_FIELDS  per-field op at [2i +: 2]: 00 keep, 01 replace, 10 OR, 11 clear (in & ~param).
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  downstream accepts when out_valid & out_ready.
REQ-015 action_out  output  ACTION_WIDTH  modified action word.
REQ-016 changed  output  1  action_out differs from the originating action_in.
REQ-017 mod_count  output  COUNT_WIDTH  count of delivered results with changed=1.
REQ-018 clear_count  input  1  synchronous clear of mod_count.

Function
REQ-019 SHALL be a two-stage pipeline: S1 registers the merged action word and the original action_in; S2 registers action_out and changed (compare of S1 merged vs original).
REQ-020 SHALL have latency exactly 2 cycles from input handshake to out_valid when out_ready stays 1.
REQ-021 SHALL sustain one request per cycle with out_ready held 1.
REQ-022 SHALL advance S2 when out_valid=0 or out_ready=1; S1 when S1 empty or S2 advances; in_ready = (S1 empty or S2 advances) and reset=0.
REQ-023 SHALL hold action_out, changed, out_valid stable while out_valid=1 and out_ready=0; no request lost or duplicated under any backpressure pattern.
REQ-024 SHALL apply field i's op to bits [FIELD_POS_i +: FIELD_WIDTH_i] only; bits outside every field pass through from action_in.
REQ-025 SHALL ignore fields with FIELD_WIDTH_i = 0; on overlap the highest-indexed field with non-keep mode wins.
REQ-026 SHALL increment mod_count on each output handshake with changed=1, saturating at all-ones.
REQ-027 SHALL give clear_count priority over a simultaneous increment: mod_count becomes 0.
REQ-028 SHALL not stall on clear_count; pipeline flow unaffected.

Reset
REQ-029 SHALL while reset=1 force S1/S2 valid to 0, action_out 0, changed 0, mod_count 0, in_ready 0.
REQ-030 SHALL discard in-flight requests on reset mid-operation; first out_valid after reset only from a post-reset handshake.

Verification
REQ-031 ACTION_WIDTH=32, fields {pos0 w8, pos8 w8}; action_in 0x1234_56F0, param 0x0000_AB0F, mode=2'b01_10 -> after 2 cycles action_out 0x1234_ABFF, changed 1, mod_count 1.
REQ-032 Same config, mode=00_00 -> action_out 0x1234_56F0, changed 0, mod_count unchanged; mode field1=11 with param 0x0000_0600 -> action_out 0x1234_50F0.
REQ-033 Back-to-back 8 requests, out_ready toggling 1,0,0,1,... -> all 8 results delivered in order, each held stable while stalled, in_ready 0 only when both stages full and out_ready=0.
REQ-034 COUNT_WIDTH=4, 17 changed results -> mod_count saturates at 0xF; clear_count in same cycle as a changed handshake -> mod_count 0.
REQ-035 Reset asserted with both stages valid -> next cycle out_valid 0, action_out 0, mod_count 0; no stale output after release.
REQ-036 Overlap config field0 pos0 w8, field1 pos4 w8, both replace -> bits [11:4] from param via field1, [3:0] from param via field0.
